column_feeder7: RTL and testbench

Streaming 7-row column generator for the 7x7 median filter path. Accepts one 8-bit pixel per valid cycle in raster order and buffers the six previous image lines. For every pixel from row 6 onward it emits the seven vertically aligned pixels of the current column as S1..S7, with a done_o strobe. It drives the column-sort stage (SortAscending7) directly, which makes it the producer end of that stage's S1..S7/done interface.

---
 rtl/column_feeder7.sv | 102 ++++++++++
 tb/tb_column_feeder7.sv | 138 +++++++++++++
 2 files changed

// File: rtl/column_feeder7.sv
// 7-row column generator: six line memories shift each column vertically so the
// current pixel and the six pixels above it leave together as S1 (oldest) .. S7.
module column_feeder7 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] data_i,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic [7:0] S3,
  output logic [7:0] S4,
  output logic [7:0] S5,
  output logic [7:0] S6,
  output logic [7:0] S7,
  output logic       done_o
);

  localparam int DATA_W = 8;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [2:0]       FILL_MAX = 3'd6;

  logic [DATA_W-1:0] line_q [6][IMG_WIDTH];
  logic [DATA_W-1:0] rd     [6];

  logic [DATA_W-1:0] pix_q [7];
  logic [DATA_W-1:0] pix_d [7];
  logic              done_q, done_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [2:0]        fill_q, fill_d;

  always_comb begin
    for (int k = 0; k < 6; k++) rd[k] = line_q[k][col_q];
  end

  // Line memories: read-before-write vertical shift at the shared column address.
  always_ff @(posedge clk) begin
    if (done_i && !rst) begin
      line_q[0][col_q] <= data_i;
      for (int k = 1; k < 6; k++) line_q[k][col_q] <= rd[k-1];
    end
  end

  always_comb begin
    pix_d  = pix_q;
    done_d = 1'b0;
    col_d  = col_q;
    row_d  = row_q;
    fill_d = fill_q;
    if (done_i) begin
      pix_d[6] = data_i;
      for (int k = 0; k < 6; k++) pix_d[5-k] = rd[k];
      // fill only reaches 6 once six complete lines sit in the memories
      done_d = (fill_q == FILL_MAX);
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          fill_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Output/counter register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) pix_q[k] <= '0;
      done_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      fill_q <= '0;
    end else begin
      pix_q  <= pix_d;
      done_q <= done_d;
      col_q  <= col_d;
      row_q  <= row_d;
      fill_q <= fill_d;
    end
  end

  assign S1     = pix_q[0];
  assign S2     = pix_q[1];
  assign S3     = pix_q[2];
  assign S4     = pix_q[3];
  assign S5     = pix_q[4];
  assign S6     = pix_q[5];
  assign S7     = pix_q[6];
  assign done_o = done_q;

endmodule

// File: tb/tb_column_feeder7.sv
// Directed bench for column_feeder7 on an 8x10 image with pixel value row*8+col(+offset).
module tb_column_feeder7;

  logic       clk;
  logic       rst;
  logic       done_i;
  logic [7:0] data_i;
  logic [7:0] S1, S2, S3, S4, S5, S6, S7;
  logic       done_o;
  logic [55:0] obs;

  int n_cmp = 0;
  int n_err = 0;
  int strobes;
  logic [55:0] last_exp = '0;

  column_feeder7 #(.IMG_WIDTH(8), .IMG_HEIGHT(10)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6), .S7(S7),
    .done_o(done_o)
  );

  assign obs = {S1, S2, S3, S4, S5, S6, S7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step(input logic r, input logic d, input logic [7:0] v);
    @(negedge clk);
    rst = r; done_i = d; data_i = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] exps(input int r, input int c, input int off);
    logic [55:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) v[(6-k)*8 +: 8] = 8'((r - 6 + k) * 8 + c + off);
    return v;
  endfunction

  task automatic pix(input int r, input int c, input int off);
    step(1'b0, 1'b1, 8'(r * 8 + c + off));
    if (done_o === 1'b1) strobes++;
    chk("done", {63'd0, done_o}, {63'd0, (r >= 6)});
    if (r >= 6) begin
      last_exp = exps(r, c, off);
      chk("column", {8'd0, obs}, {8'd0, last_exp});
    end
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      step(1'b0, 1'b0, 8'($urandom));
      chk("gap_done", {63'd0, done_o}, 64'd0);
      chk("gap_hold", {8'd0, obs}, {8'd0, last_exp});
    end
  endtask

  initial begin
    logic ok;
    rst = 1'b1; done_i = 1'b0; data_i = '0;
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    chk("reset_done", {63'd0, done_o}, 64'd0);
    chk("reset_cols", {8'd0, obs}, 64'd0);

    // Frame A: continuous stream
    strobes = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 8; c++) begin
        pix(r, c, 0);
        if (r == 5 && c == 7) chk("no_strobe_48", strobes, 0);
        if (r == 6 && c == 0) chk("first_strobe", {8'd0, obs}, {8'd0, 56'h00_08_10_18_20_28_30});
      end
    chk("last_pixel", {8'd0, obs}, {8'd0, 56'h1F_27_2F_37_3F_47_4F});
    chk("strobes_A", strobes, 32);

    // Frame B: gaps of 1..3 cycles before every row-7 pixel
    strobes = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 8; c++) begin
        if (r == 7) gap($urandom_range(1, 3));
        pix(r, c, 0);
        if (r == 0 && c == 0) chk("new_frame_quiet", {63'd0, done_o}, 64'd0);
        if (r == 7 && c == 3) chk("gap_col3", {8'd0, obs}, {8'd0, 56'h0B_13_1B_23_2B_33_3B});
      end
    chk("strobes_B", strobes, 32);

    // Frame C: reset mid-frame after pixel (7,2)
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (r < 7 || c < 3) pix(r, c, 0);
    step(1'b1, 1'b0, 8'd0);
    chk("midrst_done", {63'd0, done_o}, 64'd0);
    chk("midrst_cols", {8'd0, obs}, 64'd0);

    strobes = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 8; c++) begin
        pix(r, c, 100);
        if (r == 6 && c == 0) chk("off_first", {8'd0, obs}, {8'd0, 56'h64_6C_74_7C_84_8C_94});
      end
    chk("strobes_off", strobes, 32);

    // rst together with done_i: pixel dropped, frame restarts at (0,0)
    for (int c = 0; c < 3; c++) pix(0, c, 0);
    step(1'b1, 1'b1, 8'hAA);
    chk("rstdone_done", {63'd0, done_o}, 64'd0);
    chk("rstdone_cols", {8'd0, obs}, 64'd0);

    // Two frames back to back
    strobes = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 8; c++) begin
          pix(r, c, 0);
          if (done_o === 1'b1) begin
            ok = (S2 - S1 == 8'd8) && (S3 - S2 == 8'd8) && (S4 - S3 == 8'd8) &&
                 (S5 - S4 == 8'd8) && (S6 - S5 == 8'd8) && (S7 - S6 == 8'd8);
            chk("step8", {63'd0, ok}, 64'd1);
          end
        end
    chk("strobes_2f", strobes, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
